// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state encoding and the register-file numbering constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int DEF_MAX_WAIT = 15;
  localparam int REG_W        = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Writes to $zero never create a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             i_mem_to_reg_e,
  input  logic [REG_W-1:0] i_write_reg_e,
  input  logic [REG_W-1:0] i_rs_d,
  input  logic [REG_W-1:0] i_rt_d,
  input  logic             i_uses_rs_d,
  input  logic             i_uses_rt_d,
  output logic             o_hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_uses_rs_d && (i_rs_d == i_write_reg_e);
  assign w_rt_hit = i_uses_rt_d && (i_rt_d == i_write_reg_e);

  assign o_hazard = i_mem_to_reg_e && (i_write_reg_e != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait FSM with timeout,
// load-use interlock, branch flush priority mux and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic             MemtoRegE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             UsesRsD,
  input  logic             UsesRtD,
  input  logic             PCSrcD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic w_mem_stall;
  logic w_load_use;
  logic w_lu_stall;
  logic w_stall_f;

  load_use_detect u_load_use_detect (
    .i_mem_to_reg_e (MemtoRegE),
    .i_write_reg_e  (WriteRegE),
    .i_rs_d         (RsD),
    .i_rt_d         (RtD),
    .i_uses_rs_d    (UsesRsD),
    .i_uses_rt_d    (UsesRtD),
    .o_hazard       (w_load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Ack in MEM_WAIT releases the pipeline in the same cycle, even if MemReqM dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_mem_stall = 1'b0;
    case (r_state)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          w_mem_stall = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wait_cnt == WAIT_MAX) begin
            w_state_nxt = ERROR;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_ONE;
          end
        end
      end
      ERROR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  assign w_lu_stall = w_load_use && !w_mem_stall;
  assign w_stall_f  = reset || w_mem_stall || w_lu_stall;

  always_comb begin
    StallF  = w_stall_f;
    StallD  = w_stall_f;
    StallE  = reset || w_mem_stall;
    StallM  = reset || w_mem_stall;
    BubbleW = reset || w_mem_stall;
    FlushE  = reset || w_lu_stall;
    // A branch seen while ID is held is re-resolved once the stall lifts.
    FlushD  = reset || (PCSrcD && !w_mem_stall && !w_lu_stall);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_err <= 1'b0;
    end else if (w_state_nxt == ERROR) begin
      r_mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall_f && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign MemErr      = r_mem_err;
  assign StallCycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them against two instances (CNT_W=32 and CNT_W=4).
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic       ack;
    logic       mtr;
    logic [4:0] wr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       pc;
  } in_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, MemErr}
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b1100_0100;
  localparam logic [7:0] E_FD   = 8'b0000_1000;
  localparam logic [7:0] E_MEM  = 8'b1111_0010;
  localparam logic [7:0] E_ERR  = 8'b1111_0011;
  localparam logic [7:0] E_RST  = 8'b1111_1110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, MemReqM, MemAckM, MemtoRegE, UsesRsD, UsesRtD, PCSrcD;
  logic [4:0] WriteRegE, RsD, RtD;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, MemErr;
  logic [31:0] StallCycles;
  logic       StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, BubbleW4, MemErr4;
  logic [3:0] StallCycles4;

  pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .RsD(RsD), .RtD(RtD),
    .UsesRsD(UsesRsD), .UsesRtD(UsesRtD), .PCSrcD(PCSrcD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleW(BubbleW), .MemErr(MemErr),
    .StallCycles(StallCycles)
  );

  pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .RsD(RsD), .RtD(RtD),
    .UsesRsD(UsesRsD), .UsesRtD(UsesRtD), .PCSrcD(PCSrcD),
    .StallF(StallF4), .StallD(StallD4), .StallE(StallE4), .StallM(StallM4),
    .FlushD(FlushD4), .FlushE(FlushE4), .BubbleW(BubbleW4), .MemErr(MemErr4),
    .StallCycles(StallCycles4)
  );

  logic [51:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  int          exp_cnt4 = 0;

  function automatic in_t mk(input logic rst, input logic req, input logic ack, input logic mtr,
                             input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic pc);
    in_t v;
    v.rst = rst; v.req = req; v.ack = ack; v.mtr = mtr;
    v.wr = wr; v.rs = rs; v.rt = rt;
    v.urs = urs; v.urt = urt; v.pc = pc;
    return v;
  endfunction

  task automatic drive(input in_t i);
    {reset, MemReqM, MemAckM, MemtoRegE, WriteRegE, RsD, RtD, UsesRsD, UsesRtD, PCSrcD} = i;
  endtask

  // Expected word: {outputs(8), dut4 outputs(8), StallCycles(32), StallCycles4(4)}
  task automatic step(input string nm, input in_t i, input logic [7:0] e);
    @(posedge clk);
    #1;
    drive(i);
    if (i.rst) begin
      exp_cnt  = 0;
      exp_cnt4 = 0;
    end
    exp_q.push_back({e, e, 32'(exp_cnt), 4'(exp_cnt4)});
    name_q.push_back(nm);
    if (!i.rst && e[7]) begin
      exp_cnt = exp_cnt + 1;
      if (exp_cnt4 < 15) exp_cnt4 = exp_cnt4 + 1;
    end
  endtask

  initial begin : monitor
    logic [51:0] ex;
    logic [51:0] act;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ex  = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, MemErr,
               StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, BubbleW4, MemErr4,
               StallCycles, StallCycles4};
        n_cmp = n_cmp + 1;
        if (act !== ex) begin
          n_err = n_err + 1;
          $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
      end
    end
  end

  initial begin : stimulus
    in_t idle;
    idle = mk(L, L, L, L, 5'd0, 5'd0, 5'd0, L, L, L);
    drive(mk(H, L, L, L, 5'd0, 5'd0, 5'd0, L, L, L));

    // Reset forces all enables regardless of inputs
    step("rst_forced", mk(H, H, L, H, 5'd8, 5'd8, 5'd0, H, L, H), E_RST);
    step("rst_hold",   mk(H, L, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_RST);
    step("idle",       idle, E_NONE);

    // Load-use interlock
    step("lu_rs",        mk(L, L, L, H, 5'd8, 5'd8, 5'd0, H, L, L), E_LU);
    step("lu_rs_after",  idle, E_NONE);
    step("lu_r0",        mk(L, L, L, H, 5'd0, 5'd0, 5'd0, H, L, L), E_NONE);
    step("lu_rt",        mk(L, L, L, H, 5'd9, 5'd3, 5'd9, H, H, L), E_LU);
    step("lu_rt_unused", mk(L, L, L, H, 5'd9, 5'd3, 5'd9, H, L, L), E_NONE);
    step("lu_noload",    mk(L, L, L, L, 5'd8, 5'd8, 5'd0, H, L, L), E_NONE);

    // Branch flush and its suppression under a stall
    step("br",     mk(L, L, L, L, 5'd0, 5'd0, 5'd0, L, L, H), E_FD);
    step("br_off", idle, E_NONE);
    step("br_lu",  mk(L, L, L, H, 5'd8, 5'd8, 5'd0, H, L, H), E_LU);

    // Memory access acked three cycles after request
    step("mem_req",   mk(L, H, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_MEM);
    step("mem_w1_lu", mk(L, H, L, H, 5'd8, 5'd8, 5'd0, H, L, H), E_MEM);
    step("mem_w2",    mk(L, H, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_MEM);
    step("mem_ack",   mk(L, H, H, L, 5'd0, 5'd0, 5'd0, L, L, L), E_NONE);
    step("mem_after", idle, E_NONE);

    // Zero-wait access and a stray ack
    step("zw",            mk(L, H, H, L, 5'd0, 5'd0, 5'd0, L, L, L), E_NONE);
    step("zw_next",       idle, E_NONE);
    step("ack_only",      mk(L, L, H, L, 5'd0, 5'd0, 5'd0, L, L, L), E_NONE);
    step("ack_only_next", idle, E_NONE);

    // Timeout: request cycle + 15 MEM_WAIT cycles, request drops partway
    step("to_req", mk(L, H, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_MEM);
    for (int k = 0; k < 15; k++) begin
      step("to_wait", mk(L, (k < 5) ? H : L, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_MEM);
    end
    step("to_err", idle, E_ERR);
    for (int k = 0; k < 3; k++) begin
      step("err_sticky", mk(L, H, H, H, 5'd8, 5'd8, 5'd0, H, L, H), E_ERR);
    end

    // Reset out of ERROR, then reset during MEM_WAIT cycle 2
    step("rst_err",    mk(H, L, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_RST);
    step("rst_err_rel", idle, E_NONE);
    step("mw_req",     mk(L, H, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_MEM);
    step("mw_c1",      mk(L, H, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_MEM);
    step("mw_c2_rst",  mk(H, H, L, L, 5'd0, 5'd0, 5'd0, L, L, L), E_RST);
    step("rel",        idle, E_NONE);
    step("rel_zw",     mk(L, H, H, L, 5'd0, 5'd0, 5'd0, L, L, L), E_NONE);

    // 20 stall cycles: the 4-bit counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      step("sat_lu", mk(L, L, L, H, 5'd4, 5'd4, 5'd0, H, L, L), E_LU);
    end
    step("sat_end",  idle, E_NONE);
    step("sat_hold", idle, E_NONE);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
